regfile: RTL and testbench
==========================

Name: regfile

Overview:
- General-purpose register file for the 5-stage pipeline.
- Consumes the write-back triple (wdata, addr, wd) driven by the MEM/WB pipeline register.
- Serves two combinational read ports to the ID stage.
- Commits writes on the rising clock edge, with same-cycle write-to-read bypass so ID sees a value being written back in that cycle.
- Keeps a free-running commit counter for performance/debug visibility.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- CNT_W, 32, width of the commit counter

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- we  in  1  write enable from MEM/WB wd
- waddr  in  ADDR_W  write index from MEM/WB addr
- wdata  in  DATA_W  write data from MEM/WB wdata
- re1  in  1  read enable, port 1
- raddr1  in  ADDR_W  read index, port 1
- rdata1  out  DATA_W  read data, port 1 (combinational)
- re2  in  1  read enable, port 2
- raddr2  in  ADDR_W  read index, port 2
- rdata2  out  DATA_W  read data, port 2 (combinational)
- commit_cnt  out  CNT_W  number of architecturally effective writes since reset

Behaviour:
- Storage: 2**ADDR_W entries of DATA_W bits.
- Entry 0 is hardwired zero: it is never written and always reads 0.
- Reset:
  - rst=0 asynchronously clears every entry and commit_cnt to 0.
  - While rst=0, rdata1 and rdata2 are forced to 0.
  - Release is synchronous to the next posedge in effect: the first write can commit on the first posedge with rst=1.
- Write: on posedge with rst=1, we=1 and waddr!=0, the entry at waddr takes wdata. This is a single-cycle write with no handshake and no stall.
- Effective write: we=1 and waddr!=0. On each effective write, commit_cnt increments by 1 and wraps modulo 2**CNT_W. Writes with we=1 and waddr=0 are discarded and not counted.
- Read port n, priority order (combinational, zero latency):
  1. rst=0 -> 0
  2. ren=0 -> 0
  3. raddrn=0 -> 0
  4. we=1 and waddr==raddrn -> wdata (bypass)
  5. otherwise -> stored entry
- Simultaneous events:
  - Both ports may read the same index; both receive the same value, with bypass applied to each independently.
  - A read and a write to the same nonzero index in the same cycle return the new data on the read.
  - After the edge, the stored value equals that data.
- Reset mid-operation: a write presented in the same cycle rst falls is lost. Contents are 0 after reset regardless of prior writes.
- No X propagation: unused/disabled ports output 0, never the stored entry.

Optional Feature:
- Macro: REGFILE_DEBUG_PORT_EN
- When defined, add a third read-only port:
  - dbg_raddr in ADDR_W
  - dbg_rdata out DATA_W
- dbg_rdata always returns the stored entry:
  - no enable and no bypass, so it shows committed state only;
  - 0 for index 0 or during reset.
- When undefined, the ports do not exist and no extra logic is generated.

Decomposition:
- Shared package/header holds:
  - DATA_W, ADDR_W defaults;
  - the ZERO_WORD constant (32'h0);
  - REG_ZERO index (5'd0);
  - write/read enable and disable constants, shared with men_wb and the ID stage.
- One natural sub-module: regfile_rd_port, the bypass/zero mux.
  - Inputs: rst, ren, raddr, we, waddr, wdata, stored word.
  - Output: rdata.
  - Instantiated twice.
- Storage, write logic and commit counter stay in the top module.

Test Plan:
- Reset check: assert rst=0 mid-run after writing r5=32'hDEAD_BEEF, then release -> r5 reads 0, commit_cnt=0, rdata1/2=0 during reset.
- Basic write/read: we=1, waddr=3, wdata=32'h1234_5678 on one edge; next cycle re1=1, raddr1=3 -> rdata1=32'h1234_5678; commit_cnt=1.
- Zero register: we=1, waddr=0, wdata=32'hFFFF_FFFF -> raddr1=0 reads 0 that cycle and after; commit_cnt unchanged.
- Bypass: r7 holds 32'hA; in the same cycle we=1, waddr=7, wdata=32'hB with re1=re2=1, raddr1=raddr2=7 -> both rdata=32'hB; after the edge a stored read gives 32'hB.
- Read enable: re2=0, raddr2=7 with r7=32'hB -> rdata2=0.
- Counter wrap (CNT_W=4 override): 17 effective writes -> commit_cnt=1; the debug port (if enabled) shows committed values only, with no bypass.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and constants for the register file,
// the MEM/WB register and the ID stage.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  localparam logic WE_EN  = 1'b1;
  localparam logic WE_DIS = 1'b0;
  localparam logic RE_EN  = 1'b1;
  localparam logic RE_DIS = 1'b0;

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port with reset/enable
// masking, hardwired-zero index and write-back bypass.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              rst,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] rdata
);

  // Conditions overlap, so evaluation order is the priority.
  always_comb begin
    rdata = DATA_W'(ZERO_WORD);
    if (!rst) begin
      rdata = DATA_W'(ZERO_WORD);
    end else if (ren != RE_EN) begin
      rdata = DATA_W'(ZERO_WORD);
    end else if (raddr == ADDR_W'(REG_ZERO)) begin
      rdata = DATA_W'(ZERO_WORD);
    end else if (we == WE_EN && waddr == raddr) begin
      rdata = wdata;
    end else begin
      rdata = rd_word;
    end
  end

endmodule

// File: rtl/regfile.sv
// regfile: 2R1W register file with write-back bypass and commit counter.
// Define REGFILE_DEBUG_PORT_EN for a committed-state debug read port.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
`ifdef REGFILE_DEBUG_PORT_EN
  output logic [CNT_W-1:0]  commit_cnt,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
`else
  output logic [CNT_W-1:0]  commit_cnt
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_commit_cnt;
  logic              w_wr_eff;

  assign w_wr_eff = (we == WE_EN) &&
                    (waddr != ADDR_W'(REG_ZERO));

  // Entry 0 is never written, so it stays at its reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_commit_cnt <= '0;
    end else if (w_wr_eff) begin
      r_mem[waddr] <= wdata;
      r_commit_cnt <= r_commit_cnt + CNT_W'(1);
    end
  end

  assign commit_cnt = r_commit_cnt;

  regfile_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd1 (
    .rst     (rst),
    .ren     (re1),
    .raddr   (raddr1),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .rd_word (r_mem[raddr1]),
    .rdata   (rdata1)
  );

  regfile_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd2 (
    .rst     (rst),
    .ren     (re2),
    .raddr   (raddr2),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .rd_word (r_mem[raddr2]),
    .rdata   (rdata2)
  );

`ifdef REGFILE_DEBUG_PORT_EN
  // Committed state only: no enable, no bypass.
  assign dbg_rdata =
    (!rst || dbg_raddr == ADDR_W'(REG_ZERO)) ?
    DATA_W'(ZERO_WORD) : r_mem[dbg_raddr];
`endif

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed vector table, reset/wrap sequences and random
// traffic against an array-based reference model.
module tb_regfile;

  localparam int CW = 4;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [CW-1:0] commit_cnt;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
`endif

  int checks;
  int errors;

  logic [31:0] m_mem [32];
  int unsigned m_cnt;

  regfile #(
    .DATA_W (32),
    .ADDR_W (5),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .re1        (re1),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .re2        (re2),
    .raddr2     (raddr2),
    .rdata2     (rdata2),
`ifdef REGFILE_DEBUG_PORT_EN
    .commit_cnt (commit_cnt),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata)
`else
    .commit_cnt (commit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [CW-1:0] expc;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_cnt = 0;
  endtask

  function automatic logic [31:0] m_rd(input logic re,
                                       input logic [4:0] ra);
    if (!rst || !re || ra == 5'd0) return 32'h0;
    if (we && waddr == ra) return wdata;
    return m_mem[ra];
  endfunction

  function automatic logic [31:0] m_dbg(input logic [4:0] ra);
    if (!rst || ra == 5'd0) return 32'h0;
    return m_mem[ra];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else if (we && waddr != 5'd0) begin
      m_mem[waddr] = wdata;
      m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic chk_model();
    chk("rd1", rdata1, m_rd(re1, raddr1));
    chk("rd2", rdata2, m_rd(re2, raddr2));
    chk("cnt", 32'(commit_cnt), 32'(m_cnt % 16));
`ifdef REGFILE_DEBUG_PORT_EN
    chk("dbg", dbg_rdata, m_dbg(dbg_raddr));
`endif
  endtask

  task automatic set_in(input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic r1,
                        input logic [4:0] a1, input logic r2,
                        input logic [4:0] a2);
    we = w; waddr = wa; wdata = wd;
    re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_clear();
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_raddr = 5'd0;
`endif
    rst = 1'b0;
    set_in(1'b1, 5'd4, 32'h5555_5555, 1'b1, 5'd4, 1'b1, 5'd4);
    #1;
    chk("rst_rd1", rdata1, 32'h0);
    chk("rst_rd2", rdata2, 32'h0);
    chk("rst_cnt", 32'(commit_cnt), 32'h0);
    tick();
    rst = 1'b1;

    vecs[0] = '{1, 3, 32'h1234_5678, 1, 3, 0, 3,
                32'h1234_5678, 32'h0, 4'd0};
    vecs[1] = '{0, 0, 32'h0, 1, 3, 1, 0,
                32'h1234_5678, 32'h0, 4'd1};
    vecs[2] = '{1, 0, 32'hFFFF_FFFF, 1, 0, 1, 3,
                32'h0, 32'h1234_5678, 4'd1};
    vecs[3] = '{1, 7, 32'hA, 1, 0, 1, 7,
                32'h0, 32'hA, 4'd1};
    vecs[4] = '{1, 7, 32'hB, 1, 7, 1, 7,
                32'hB, 32'hB, 4'd2};
    vecs[5] = '{0, 0, 32'h0, 1, 7, 0, 7,
                32'hB, 32'h0, 4'd3};
    vecs[6] = '{0, 0, 32'h0, 1, 0, 1, 7,
                32'h0, 32'hB, 4'd3};

    for (int i = 0; i < 7; i++) begin
      set_in(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re1,
             vecs[i].ra1, vecs[i].re2, vecs[i].ra2);
      #1;
      chk($sformatf("vec%0d_rd1", i), rdata1, vecs[i].exp1);
      chk($sformatf("vec%0d_rd2", i), rdata2, vecs[i].exp2);
      chk($sformatf("vec%0d_cnt", i), 32'(commit_cnt),
          32'(vecs[i].expc));
      tick();
    end

    // Reset mid-run discards r5 and a write presented with rst low.
    set_in(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    tick();
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    #1;
    chk("pre_rst_r5", rdata1, 32'hDEAD_BEEF);
    rst = 1'b0;
    set_in(1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd5, 1'b1, 5'd5);
    #1;
    chk("mid_rst_rd1", rdata1, 32'h0);
    chk("mid_rst_rd2", rdata2, 32'h0);
    chk("mid_rst_cnt", 32'(commit_cnt), 32'h0);
    tick();
    rst = 1'b1;
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd3);
    #1;
    chk("post_rst_r5", rdata1, 32'h0);
    chk("post_rst_r3", rdata2, 32'h0);
    chk("post_rst_cnt", 32'(commit_cnt), 32'h0);
    tick();

    // 17 effective writes wrap a 4-bit counter to 1.
    for (int i = 0; i < 17; i++) begin
      set_in(1'b1, 5'((i % 31) + 1), 32'(i + 100),
             1'b1, 5'((i % 31) + 1), 1'b0, 5'd0);
`ifdef REGFILE_DEBUG_PORT_EN
      dbg_raddr = 5'((i % 31) + 1);
`endif
      #1;
      chk_model();
      tick();
    end
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd17, 1'b1, 5'd1);
    #1;
    chk("wrap_cnt", 32'(commit_cnt), 32'h1);
    chk("wrap_r17", rdata1, 32'd116);
    tick();

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      set_in(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
             $urandom, 1'($urandom_range(0, 3) != 0),
             5'($urandom_range(0, 7)),
             1'($urandom_range(0, 3) != 0),
             5'($urandom_range(0, 7)));
`ifdef REGFILE_DEBUG_PORT_EN
      dbg_raddr = 5'($urandom_range(0, 7));
`endif
      if (!rst) model_clear();
      #1;
      chk_model();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
